pwm_cfg_sequencer: RTL and testbench

Controller that sequences the PWM timebase counter and owns its configuration. It accepts new period/prescale/direction settings over a valid/ready handshake and holds them in a one-deep shadow register. The settings reach the counter either immediately, with a counter restart, or glitch-free at the next wrap boundary. It also drives the counter's en and count_reset lines from start/stop commands. It sits between the register interface and the counter.

---
 rtl/pwm_cfg_sequencer.sv | 157 +++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_sequencer.sv
// PWM timebase sequencer: owns the counter's period/prescale/direction through a
// one-deep shadow and drives its en/count_reset lines from start/stop commands.
module pwm_cfg_sequencer #(
  parameter int unsigned       CNT_W         = 16,
  parameter int unsigned       PSC_W         = 8,
  parameter logic [CNT_W-1:0]  RST_PERIOD    = 16'h00FF,
  parameter logic [PSC_W-1:0]  RST_PRESCALE  = 8'h00,
  parameter logic              RST_UPNOTDOWN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [PSC_W-1:0] cfg_prescale,
  input  logic             cfg_upnotdown,
  input  logic             cfg_immediate,
  input  logic [CNT_W-1:0] count_val,
  output logic             en,
  output logic             count_reset,
  output logic [CNT_W-1:0] period,
  output logic [PSC_W-1:0] prescale,
  output logic             upnotdown,
  output logic             update_done,
  output logic             pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [CNT_W-1:0] r_prev_cnt;
  logic [CNT_W-1:0] r_sh_period;
  logic [PSC_W-1:0] r_sh_prescale;
  logic             r_sh_upnotdown;
  logic             r_en;
  logic             r_count_reset;
  logic             r_update_done;
  logic             r_pending;
  logic [CNT_W-1:0] r_period;
  logic [PSC_W-1:0] r_prescale;
  logic             r_upnotdown;

  logic             w_hs;
  logic             w_bnd;
  logic [CNT_W-1:0] w_start_val;
  logic             w_load_cfg;
  logic             w_load_sh;
  logic             w_latch;
  logic             w_crst;
  logic             w_pending;

  assign cfg_ready   = (r_state != PEND);
  assign w_hs        = cfg_valid && cfg_ready;
  assign w_start_val = r_upnotdown ? '0 : r_period;
  assign w_bnd       = (count_val != r_prev_cnt) && (count_val == w_start_val);

  assign en          = r_en;
  assign count_reset = r_count_reset;
  assign update_done = r_update_done;
  assign pending     = r_pending;
  assign period      = r_period;
  assign prescale    = r_prescale;
  assign upnotdown   = r_upnotdown;

  always_comb begin
    w_nstate   = r_state;
    w_load_cfg = 1'b0;
    w_load_sh  = 1'b0;
    w_latch    = 1'b0;
    w_crst     = 1'b0;
    w_pending  = r_pending;
    unique case (r_state)
      IDLE: begin
        w_load_cfg = w_hs;
        if (start && !stop) begin
          w_nstate = RUN;
          w_crst   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          // a config offered alongside stop lands as a plain idle-style load
          w_nstate   = IDLE;
          w_load_cfg = w_hs;
        end else if (w_hs) begin
          if (cfg_immediate) begin
            w_load_cfg = 1'b1;
            w_crst     = 1'b1;
          end else begin
            w_latch   = 1'b1;
            w_pending = 1'b1;
            w_nstate  = PEND;
          end
        end
      end
      PEND: begin
        if (stop) begin
          w_nstate  = IDLE;
          w_load_sh = 1'b1;
          w_pending = 1'b0;
        end else if (w_bnd || (r_period == '0)) begin
          // zero period never produces a boundary, so apply without waiting
          w_nstate  = RUN;
          w_load_sh = 1'b1;
          w_pending = 1'b0;
          w_crst    = (r_sh_upnotdown != r_upnotdown);
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    r_prev_cnt <= count_val;
    if (rst) begin
      r_state        <= IDLE;
      r_en           <= 1'b0;
      r_count_reset  <= 1'b0;
      r_update_done  <= 1'b0;
      r_pending      <= 1'b0;
      r_period       <= RST_PERIOD;
      r_prescale     <= RST_PRESCALE;
      r_upnotdown    <= RST_UPNOTDOWN;
      r_sh_period    <= '0;
      r_sh_prescale  <= '0;
      r_sh_upnotdown <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_en          <= (w_nstate != IDLE);
      r_count_reset <= w_crst;
      r_update_done <= w_load_cfg || w_load_sh;
      r_pending     <= w_pending;
      if (w_load_cfg) begin
        r_period    <= cfg_period;
        r_prescale  <= cfg_prescale;
        r_upnotdown <= cfg_upnotdown;
      end else if (w_load_sh) begin
        r_period    <= r_sh_period;
        r_prescale  <= r_sh_prescale;
        r_upnotdown <= r_sh_upnotdown;
      end
      if (w_latch) begin
        r_sh_period    <= cfg_period;
        r_sh_prescale  <= cfg_prescale;
        r_sh_upnotdown <= cfg_upnotdown;
      end
    end
  end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Bench for pwm_cfg_sequencer: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the controller.
module tb_pwm_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_period = '0;
  logic [7:0]  cfg_prescale = '0;
  logic        cfg_upnotdown = 1'b1;
  logic        cfg_immediate = 1'b0;
  logic [15:0] count_val = '0;
  logic        en, count_reset, upnotdown, update_done, pending;
  logic [15:0] period;
  logic [7:0]  prescale;

  pwm_cfg_sequencer #(
    .CNT_W(16), .PSC_W(8), .RST_PERIOD(16'h00FF), .RST_PRESCALE(8'h00), .RST_UPNOTDOWN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
    .cfg_prescale(cfg_prescale), .cfg_upnotdown(cfg_upnotdown), .cfg_immediate(cfg_immediate),
    .count_val(count_val), .en(en), .count_reset(count_reset), .period(period),
    .prescale(prescale), .upnotdown(upnotdown), .update_done(update_done), .pending(pending)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          auto_cnt = 1'b0;

  // Model: running flag + pending flag, active and shadow configs, pulses.
  bit          m_run, m_pend, m_crst, m_upd, m_up, s_up;
  logic [15:0] m_period, s_period, m_prev;
  logic [7:0]  m_psc, s_psc;

  localparam logic [29:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 16'h00FF};

  function automatic logic [29:0] dut_vec();
    return {en, count_reset, update_done, pending, cfg_ready, upnotdown, prescale, period};
  endfunction

  function automatic logic [29:0] mdl_vec();
    return {m_run, m_crst, m_upd, m_pend, !m_pend, m_up, m_psc, m_period};
  endfunction

  task automatic model_tick();
    bit          hs;
    bit          bnd;
    logic [15:0] sv;
    hs  = cfg_valid && !m_pend;
    sv  = m_up ? 16'd0 : m_period;
    bnd = (count_val != m_prev) && (count_val == sv);
    m_crst = 1'b0;
    m_upd  = 1'b0;
    if (!m_run) begin
      if (hs) begin
        m_period = cfg_period; m_psc = cfg_prescale; m_up = cfg_upnotdown; m_upd = 1'b1;
      end
      if (start && !stop) begin
        m_run = 1'b1; m_crst = 1'b1;
      end
    end else if (stop) begin
      m_run = 1'b0;
      if (m_pend) begin
        m_period = s_period; m_psc = s_psc; m_up = s_up; m_upd = 1'b1; m_pend = 1'b0;
      end else if (hs) begin
        m_period = cfg_period; m_psc = cfg_prescale; m_up = cfg_upnotdown; m_upd = 1'b1;
      end
    end else if (m_pend) begin
      if (bnd || m_period == 16'd0) begin
        m_crst = (s_up != m_up);
        m_period = s_period; m_psc = s_psc; m_up = s_up; m_upd = 1'b1; m_pend = 1'b0;
      end
    end else if (hs) begin
      if (cfg_immediate) begin
        m_period = cfg_period; m_psc = cfg_prescale; m_up = cfg_upnotdown;
        m_upd = 1'b1; m_crst = 1'b1;
      end else begin
        s_period = cfg_period; s_psc = cfg_prescale; s_up = cfg_upnotdown; m_pend = 1'b1;
      end
    end
    m_prev = count_val;
    if (rst) begin
      m_run = 1'b0; m_pend = 1'b0; m_crst = 1'b0; m_upd = 1'b0;
      m_period = 16'h00FF; m_psc = 8'h00; m_up = 1'b1;
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    logic [15:0] nxt;
    nxt = count_val;
    if (auto_cnt) begin
      if (m_crst) nxt = 16'd0;
      else if (m_run) begin
        if (m_up) nxt = (count_val >= m_period) ? 16'd0 : count_val + 16'd1;
        else      nxt = (count_val == 16'd0 || count_val > m_period) ? m_period : count_val - 16'd1;
      end
    end
    model_tick();
    @(posedge clk);
    #1;
    if (auto_cnt) count_val = nxt;
  endtask

  task automatic offer(input logic [15:0] p, input logic [7:0] s, input logic up, input logic imm);
    cfg_valid = 1'b1; cfg_period = p; cfg_prescale = s; cfg_upnotdown = up; cfg_immediate = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    n_vec++;
    if (dut_vec() !== RESET_VEC) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", dut_vec(), RESET_VEC);
    end
    start = 1'b1; step(); start = 1'b0;
    n_vec++;
    if (!(en === 1'b1 && count_reset === 1'b1) || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL start_pulse: got %h expected %h", dut_vec(), mdl_vec());
    end
    step();
    n_vec++;
    if (count_reset !== 1'b0 || en !== 1'b1) begin
      n_err++; $display("FAIL start_crst_clear: got en=%b crst=%b expected en=1 crst=0", en, count_reset);
    end
  endtask

  task automatic test_deferred();
    count_val = 16'd3; step();
    offer(16'd5, 8'd0, 1'b1, 1'b0); step();
    offer(16'd7, 8'd1, 1'b1, 1'b0);
    n_vec++;
    if (pending !== 1'b1 || cfg_ready !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL defer_pending: got %h expected %h", dut_vec(), mdl_vec());
    end
    count_val = 16'h00FF; step();
    n_vec++;
    if (period !== 16'h00FF || pending !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL defer_stall: got %h expected %h", dut_vec(), mdl_vec());
    end
    cfg_valid = 1'b0; count_val = 16'd0; step();
    n_vec++;
    if (period !== 16'd5 || update_done !== 1'b1 || pending !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL defer_apply: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_immediate();
    offer(16'd10, 8'd2, 1'b1, 1'b1); step(); cfg_valid = 1'b0;
    n_vec++;
    if (period !== 16'd10 || prescale !== 8'd2 || count_reset !== 1'b1 || update_done !== 1'b1 ||
        en !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL immediate_apply: got %h expected %h", dut_vec(), mdl_vec());
    end
    step();
    n_vec++;
    if (count_reset !== 1'b0 || update_done !== 1'b0 || en !== 1'b1) begin
      n_err++; $display("FAIL immediate_pulse_width: got crst=%b upd=%b en=%b expected 0 0 1",
                        count_reset, update_done, en);
    end
  endtask

  task automatic test_dir_change();
    count_val = 16'd5; step();
    offer(16'd8, 8'd0, 1'b0, 1'b0); step(); cfg_valid = 1'b0;
    count_val = 16'd10; step();
    n_vec++;
    if (pending !== 1'b1 || period !== 16'd10) begin
      n_err++; $display("FAIL dir_no_early_apply: got %h expected %h", dut_vec(), mdl_vec());
    end
    count_val = 16'd0; step();
    n_vec++;
    if (upnotdown !== 1'b0 || period !== 16'd8 || count_reset !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL dir_change_apply: got %h expected %h", dut_vec(), mdl_vec());
    end
    offer(16'd0, 8'd0, 1'b1, 1'b1); step();
    offer(16'd20, 8'd4, 1'b1, 1'b0); step(); cfg_valid = 1'b0;
    n_vec++;
    if (pending !== 1'b1 || period !== 16'd0) begin
      n_err++; $display("FAIL zero_period_enter: got %h expected %h", dut_vec(), mdl_vec());
    end
    step();
    n_vec++;
    if (period !== 16'd20 || update_done !== 1'b1 || pending !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL zero_period_apply: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_stop_pend();
    offer(16'd33, 8'd3, 1'b1, 1'b0); step(); cfg_valid = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    n_vec++;
    if (en !== 1'b0 || period !== 16'd33 || update_done !== 1'b1 || pending !== 1'b0 ||
        cfg_ready !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL stop_in_pend: got %h expected %h", dut_vec(), mdl_vec());
    end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_vec++;
    if (en !== 1'b0 || count_reset !== 1'b0) begin
      n_err++; $display("FAIL start_stop_idle: got en=%b crst=%b expected 0 0", en, count_reset);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; step(); start = 1'b0;
    offer(16'd44, 8'd1, 1'b0, 1'b1); stop = 1'b1; step(); stop = 1'b0; cfg_valid = 1'b0;
    n_vec++;
    if (en !== 1'b0 || period !== 16'd44 || update_done !== 1'b1 || count_reset !== 1'b0 ||
        dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL stop_with_cfg: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_reset_pend();
    start = 1'b1; step(); start = 1'b0;
    count_val = 16'd1; step();
    offer(16'd77, 8'd9, 1'b1, 1'b0); step(); cfg_valid = 1'b0;
    n_vec++;
    if (pending !== 1'b1) begin
      n_err++; $display("FAIL rst_pend_setup: got pending=%b expected 1", pending);
    end
    rst = 1'b1; step(); rst = 1'b0;
    n_vec++;
    if (dut_vec() !== RESET_VEC) begin
      n_err++; $display("FAIL rst_in_pend: got %h expected %h", dut_vec(), RESET_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      count_val = (i == 1) ? 16'd0 : 16'd2;
      step();
      n_vec++;
      if (period === 16'd77 || dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL rst_discard_%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    auto_cnt = 1'b1;
    count_val = 16'd0;
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 79) == 0);
      start         = ($urandom_range(0, 7) == 0);
      stop          = ($urandom_range(0, 19) == 0);
      cfg_valid     = ($urandom_range(0, 2) == 0);
      cfg_period    = 16'($urandom_range(0, 6));
      cfg_prescale  = 8'($urandom);
      cfg_upnotdown = 1'($urandom);
      cfg_immediate = 1'($urandom);
      step();
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; auto_cnt = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_deferred();
    test_immediate();
    test_dir_change();
    test_stop_pend();
    test_back_to_back();
    test_reset_pend();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
